// File: rtl/peri_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : peri_timer_pkg
//  Description : Shared constants, control-register layout and byte-lane
//                merge helper for the memory-mapped machine timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package peri_timer_pkg;

    // Widest DIV field the CTRL layout can carry (bits [31:8]).
    localparam int unsigned c_div_max_w = 24;

    // Word offsets, decoded from peri_addr[4:2].
    localparam logic [2:0] c_off_mtime_lo    = 3'd0;
    localparam logic [2:0] c_off_mtime_hi    = 3'd1;
    localparam logic [2:0] c_off_mtimecmp_lo = 3'd2;
    localparam logic [2:0] c_off_mtimecmp_hi = 3'd3;
    localparam logic [2:0] c_off_ctrl        = 3'd4;
    localparam logic [2:0] c_off_status      = 3'd5;

    // CTRL bit positions.
    localparam int unsigned c_ctrl_en_bit     = 0;
    localparam int unsigned c_ctrl_irq_en_bit = 1;
    localparam int unsigned c_ctrl_div_lsb    = 8;

    // STATUS bit positions.
    localparam int unsigned c_status_pend_bit = 0;

    // Compare value after reset: nothing can match until software programs it.
    localparam logic [63:0] c_mtimecmp_rst = 64'hFFFF_FFFF_FFFF_FFFF;

    // CTRL register image, exactly 32 bits wide so it maps straight onto the bus.
    typedef struct packed {
        logic [c_div_max_w-1:0] div;
        logic [5:0]             rsvd;
        logic                   irq_en;
        logic                   en;
    } ctrl_t;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/peri_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : peri_timer_prescaler
//  Description : Divide-by-(DIV+1) tick generator for the machine timer.
//                Counts 0..div while enabled and strobes tick on the cycle
//                the count equals div.
//  Revision    : 1.0 - initial release
// ============================================================================
module peri_timer_prescaler #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             restart,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;

    // Tick is a same-cycle strobe so mtime advances on the terminal count.
    assign tick = en && (r_cnt == div);

    // Divider count; restart (a CTRL write) takes priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/peri_timer.sv
`default_nettype none
// ============================================================================
//  Module      : peri_timer
//  Description : Memory-mapped 64-bit machine timer. Decodes peri_* register
//                accesses, runs a prescaled free-running mtime counter,
//                compares it to mtimecmp and drives a level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module peri_timer
    import peri_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W   = 8,     // must not exceed c_div_max_w
    parameter logic        RESET_ENABLE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        peri_req,
    input  logic [31:0] peri_addr,
    input  logic        peri_write,
    input  logic [3:0]  peri_be,
    input  logic [31:0] peri_wdata,
    output logic        peri_gnt,
    output logic        peri_rvalid,
    output logic [31:0] peri_rdata,
    output logic        timer_irq_o
);

    // Writable CTRL bits: EN, IRQ_EN and a PRESCALE_W-wide DIV field; all
    // other bits hold zero.
    localparam logic [c_div_max_w-1:0] c_div_mask =
        {c_div_max_w{1'b1}} >> (c_div_max_w - PRESCALE_W);
    localparam logic [31:0] c_ctrl_wmask = {c_div_mask, 6'b00_0000, 1'b1, 1'b1};
    localparam ctrl_t c_ctrl_rst = '{div: '0, rsvd: '0, irq_en: 1'b0, en: RESET_ENABLE};

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [31:0] r_mtime_hi_shadow;
    ctrl_t       r_ctrl;
    logic        r_pend;
    logic        r_irq;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    logic [2:0]  w_off;
    logic        w_rd;
    logic        w_wr;
    logic        w_wr_mtime_lo;
    logic        w_wr_mtime_hi;
    logic        w_wr_cmp_lo;
    logic        w_wr_cmp_hi;
    logic        w_wr_ctrl;
    logic        w_rd_mtime_lo;
    logic        w_pend_clr;
    logic        w_match;
    logic        w_tick;
    logic [31:0] w_rdata;
    ctrl_t       w_ctrl_next;
    logic        w_unused_addr;

    assign w_off = peri_addr[4:2];
    assign w_rd  = peri_req && !peri_write;
    assign w_wr  = peri_req &&  peri_write;

    // The upstream decoder has already qualified the window; the rest is ignored.
    assign w_unused_addr = ^{peri_addr[31:5], peri_addr[1:0]};

    assign w_wr_mtime_lo = w_wr && (w_off == c_off_mtime_lo);
    assign w_wr_mtime_hi = w_wr && (w_off == c_off_mtime_hi);
    assign w_wr_cmp_lo   = w_wr && (w_off == c_off_mtimecmp_lo);
    assign w_wr_cmp_hi   = w_wr && (w_off == c_off_mtimecmp_hi);
    assign w_wr_ctrl     = w_wr && (w_off == c_off_ctrl);
    assign w_rd_mtime_lo = w_rd && (w_off == c_off_mtime_lo);

    // W1C on PEND lives in byte lane 0, so it needs that lane enabled.
    assign w_pend_clr = w_wr && (w_off == c_off_status) &&
                        peri_be[0] && peri_wdata[c_status_pend_bit];

    // Unsigned 64-bit compare on the registered values.
    assign w_match = (r_mtime >= r_mtimecmp);

    // Merged CTRL write with reserved and unused DIV bits forced low.
    assign w_ctrl_next = ctrl_t'(be_merge(r_ctrl, peri_wdata, peri_be) & c_ctrl_wmask);

    // No back-pressure: every request is granted in the cycle it appears.
    assign peri_gnt    = peri_req;
    assign peri_rvalid = r_rvalid;
    assign peri_rdata  = r_rdata;
    assign timer_irq_o = r_irq;

    // ------------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------------
    peri_timer_prescaler #(
        .DIV_W   (PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .en      (r_ctrl.en),
        .div     (r_ctrl.div[PRESCALE_W-1:0]),
        .restart (w_wr_ctrl),
        .tick    (w_tick)
    );

    // Read mux over pre-write register state; MTIME_HI returns the shadow.
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (w_off)
            c_off_mtime_lo:    w_rdata = r_mtime[31:0];
            c_off_mtime_hi:    w_rdata = r_mtime_hi_shadow;
            c_off_mtimecmp_lo: w_rdata = r_mtimecmp[31:0];
            c_off_mtimecmp_hi: w_rdata = r_mtimecmp[63:32];
            c_off_ctrl:        w_rdata = r_ctrl;
            c_off_status:      w_rdata = {31'h0000_0000, r_pend};
            default:           w_rdata = 32'h0000_0000;
        endcase
    end

    // mtime: a bus write to either half beats the increment, leaving the other
    // half at its pre-increment value so no carry leaks across.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime <= 64'h0;
        end else if (w_wr_mtime_lo) begin
            r_mtime[31:0] <= be_merge(r_mtime[31:0], peri_wdata, peri_be);
        end else if (w_wr_mtime_hi) begin
            r_mtime[63:32] <= be_merge(r_mtime[63:32], peri_wdata, peri_be);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // HI shadow captured by a LO read so a LO-then-HI pair is coherent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtime_hi_shadow <= 32'h0;
        end else if (w_rd_mtime_lo) begin
            r_mtime_hi_shadow <= r_mtime[63:32];
        end
    end

    // mtimecmp halves with byte-lane writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mtimecmp <= c_mtimecmp_rst;
        end else if (w_wr_cmp_lo) begin
            r_mtimecmp[31:0] <= be_merge(r_mtimecmp[31:0], peri_wdata, peri_be);
        end else if (w_wr_cmp_hi) begin
            r_mtimecmp[63:32] <= be_merge(r_mtimecmp[63:32], peri_wdata, peri_be);
        end
    end

    // CTRL register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl <= c_ctrl_rst;
        end else if (w_wr_ctrl) begin
            r_ctrl <= w_ctrl_next;
        end
    end

    // PEND is sticky; an active match overrides a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= w_match || (r_pend && !w_pend_clr);
        end
    end

    // Registered level interrupt gated by IRQ_EN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_pend && r_ctrl.irq_en;
        end
    end

    // One-cycle response for every granted access; data only for reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            r_rvalid <= peri_req;
            r_rdata  <= w_rd ? w_rdata : 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peri_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peri_timer
//  Description : Self-checking bench for peri_timer: directed scenarios plus
//                random bus traffic compared cycle by cycle against a
//                behavioural model of the register file and timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_peri_timer;

    logic        clk;
    logic        rst;
    logic        peri_req;
    logic [31:0] peri_addr;
    logic        peri_write;
    logic [3:0]  peri_be;
    logic [31:0] peri_wdata;
    logic        peri_gnt;
    logic        peri_rvalid;
    logic [31:0] peri_rdata;
    logic        timer_irq_o;

    int n_vec = 0;
    int n_err = 0;

    peri_timer #(
        .PRESCALE_W   (8),
        .RESET_ENABLE (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .peri_req    (peri_req),
        .peri_addr   (peri_addr),
        .peri_write  (peri_write),
        .peri_be     (peri_be),
        .peri_wdata  (peri_wdata),
        .peri_gnt    (peri_gnt),
        .peri_rvalid (peri_rvalid),
        .peri_rdata  (peri_rdata),
        .timer_irq_o (timer_irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic [31:0] m_shadow;
    logic        m_en;
    logic        m_irq_en;
    logic        m_pend;
    logic        m_irq;
    int unsigned m_div;
    int unsigned m_phase;     // enabled cycles since the last CTRL write
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mmerge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] off);
        case (off)
            3'd0:    return m_mtime[31:0];
            3'd1:    return m_shadow;
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return (32'(m_div) << 8) | {30'h0, m_irq_en, m_en};
            3'd5:    return {31'h0, m_pend};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mtime  = 64'h0;
        m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
        m_shadow = 32'h0;
        m_en     = 1'b0;
        m_irq_en = 1'b0;
        m_pend   = 1'b0;
        m_irq    = 1'b0;
        m_div    = 0;
        m_phase  = 0;
        e_rvalid = 1'b0;
        e_rdata  = 32'h0;
    endtask

    // Advance the model by one clock given this cycle's bus inputs.
    task automatic model_step(input logic req, input logic wr, input logic [2:0] off,
                              input logic [3:0] be, input logic [31:0] wd);
        logic        is_w;
        logic        is_r;
        logic        tick;
        logic        match;
        logic [31:0] c;
        is_w     = req && wr;
        is_r     = req && !wr;
        e_rvalid = req;
        e_rdata  = is_r ? m_read(off) : 32'h0;
        tick     = m_en && ((m_phase % (m_div + 1)) == m_div);
        match    = (m_mtime >= m_cmp);
        m_irq    = m_pend && m_irq_en;
        m_pend   = match || (m_pend && !(is_w && off == 3'd5 && be[0] && wd[0]));
        if (is_r && off == 3'd0) m_shadow = m_mtime[63:32];
        if (is_w && off == 3'd0)      m_mtime[31:0]  = mmerge(m_mtime[31:0], wd, be);
        else if (is_w && off == 3'd1) m_mtime[63:32] = mmerge(m_mtime[63:32], wd, be);
        else if (tick)                m_mtime        = m_mtime + 64'd1;
        if (is_w && off == 3'd2) m_cmp[31:0]  = mmerge(m_cmp[31:0], wd, be);
        if (is_w && off == 3'd3) m_cmp[63:32] = mmerge(m_cmp[63:32], wd, be);
        if (is_w && off == 3'd4) begin
            c        = mmerge(m_read(3'd4), wd, be);
            m_en     = c[0];
            m_irq_en = c[1];
            m_div    = int'(c[15:8]);
            m_phase  = 0;
        end else if (m_en) begin
            m_phase++;
        end
    endtask

    // One clock with the currently driven inputs; checks every response.
    task automatic step();
        check("gnt", peri_gnt, peri_req);
        model_step(peri_req, peri_write, peri_addr[4:2], peri_be, peri_wdata);
        @(posedge clk);
        #1;
        check("rvalid", peri_rvalid, e_rvalid);
        if (e_rvalid) check("rdata", peri_rdata, e_rdata);
        check("irq", timer_irq_o, m_irq);
        last_rdata = peri_rdata;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic bus(input logic wr, input logic [2:0] off, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd);
        peri_req   = 1'b1;
        peri_write = wr;
        peri_addr  = {27'h0, off, 2'b00};
        peri_be    = be;
        peri_wdata = wd;
        step();
        rd         = last_rdata;
        peri_req   = 1'b0;
        peri_write = 1'b0;
        peri_be    = 4'h0;
        peri_wdata = 32'h0;
    endtask

    task automatic wr32(input logic [2:0] off, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(1'b1, off, 4'hF, wd, dummy);
    endtask

    task automatic rd32(input logic [2:0] off, output logic [31:0] rd);
        bus(1'b0, off, 4'h0, 32'h0, rd);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        peri_req = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_defaults(input string pfx);
        logic [31:0] v;
        rd32(3'd0, v); check({pfx, "_mtime_lo"}, v, 32'h0);
        rd32(3'd1, v); check({pfx, "_mtime_hi"}, v, 32'h0);
        rd32(3'd2, v); check({pfx, "_cmp_lo"},   v, 32'hFFFF_FFFF);
        rd32(3'd3, v); check({pfx, "_cmp_hi"},   v, 32'hFFFF_FFFF);
        rd32(3'd4, v); check({pfx, "_ctrl"},     v, 32'h0);
        rd32(3'd5, v); check({pfx, "_status"},   v, 32'h0);
        check({pfx, "_irq"}, timer_irq_o, 1'b0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] v2;
        logic        found;
        int          t_reach;
        int          t_irq;
        logic [2:0]  off;

        rst        = 1'b1;
        peri_req   = 1'b0;
        peri_write = 1'b0;
        peri_addr  = 32'h0;
        peri_be    = 4'h0;
        peri_wdata = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset defaults; step() also checks rvalid one cycle after each grant.
        check_defaults("rst");
        idle(1);

        // Byte-enable merge over the all-ones reset value.
        bus(1'b1, 3'd2, 4'b0101, 32'hAABB_CCDD, v);
        rd32(3'd2, v); check("be_merge", v, 32'hFFBB_FFDD);

        // Prescaler DIV=3: ten ticks in forty cycles.
        wr32(3'd4, 32'h0000_0301);
        idle(40);
        rd32(3'd0, v); check("prescale_40", (v >= 32'd9 && v <= 32'd11), 1'b1);

        // DIV=0: consecutive LO reads differ by one.
        wr32(3'd4, 32'h0000_0001);
        rd32(3'd0, v);
        rd32(3'd0, v2); check("div0_step", v2 - v, 32'd1);

        // LO read at 0xFFFFFFFF latches HI=0 even though live HI then becomes 1.
        wr32(3'd1, 32'h0);
        wr32(3'd0, 32'hFFFF_FFFE);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            rd32(3'd0, v);
            if (v == 32'hFFFF_FFFF) found = 1'b1;
        end
        check("lo_seen_ffffffff", found, 1'b1);
        rd32(3'd1, v); check("hi_shadow", v, 32'h0);

        // 64-bit wrap to zero.
        wr32(3'd1, 32'hFFFF_FFFF);
        wr32(3'd0, 32'hFFFF_FFFF);
        rd32(3'd0, v); check("wrap_pre", v, 32'hFFFF_FFFF);
        rd32(3'd0, v); check("wrap_lo", v, 32'h0);
        rd32(3'd1, v); check("wrap_hi", v, 32'h0);

        // Write to LO on a tick that would carry: write wins, HI untouched.
        wr32(3'd1, 32'h5);
        wr32(3'd0, 32'hFFFF_FFFE);
        idle(1);
        wr32(3'd0, 32'h10);
        rd32(3'd0, v); check("collide_lo", v, 32'h10);
        rd32(3'd1, v); check("collide_hi", v, 32'h5);

        // Interrupt rise two cycles after mtime reaches mtimecmp.
        do_reset();
        wr32(3'd3, 32'h0);
        wr32(3'd2, 32'd20);
        wr32(3'd4, 32'h0000_0003);
        t_reach = -1;
        t_irq   = -1;
        for (int i = 0; i < 40; i++) begin
            idle(1);
            if (m_mtime == 64'd20 && t_reach < 0) t_reach = i;
            if (timer_irq_o && t_irq < 0) t_irq = i;
        end
        check("irq_rise_seen", (t_irq >= 0), 1'b1);
        check("irq_latency", 64'(t_irq - t_reach), 64'd2);

        // Clear while still matching: set wins.
        bus(1'b1, 3'd5, 4'h1, 32'h1, v);
        rd32(3'd5, v); check("w1c_while_match", v, 32'h1);

        // Remove the match, then clear: irq falls two cycles after the write.
        wr32(3'd2, 32'hFFFF_FFFF);
        wr32(3'd3, 32'hFFFF_FFFF);
        bus(1'b1, 3'd5, 4'h1, 32'h1, v);
        check("irq_hold_1", timer_irq_o, 1'b1);
        idle(1);
        check("irq_fall_2", timer_irq_o, 1'b0);
        rd32(3'd5, v); check("pend_cleared", v, 32'h0);

        // Reset in the cycle after a granted read drops its response at once.
        wr32(3'd4, 32'h0000_0203);
        wr32(3'd2, 32'd3);
        idle(5);
        rd32(3'd0, v);
        check("pre_rst_rvalid", peri_rvalid, 1'b1);
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rvalid_drop", peri_rvalid, 1'b0);
        check("async_irq_drop", timer_irq_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_defaults("post_rst");

        // Random traffic against the model; DIV kept small so ticks happen.
        for (int i = 0; i < 400; i++) begin
            off        = 3'($urandom_range(0, 7));
            peri_req   = ($urandom_range(0, 3) != 0);
            peri_write = 1'($urandom_range(0, 1));
            peri_addr  = {27'($urandom), off, 2'($urandom)};
            peri_be    = 4'($urandom);
            peri_wdata = $urandom;
            if (off == 3'd4) peri_wdata[15:8] = 8'($urandom_range(0, 3));
            step();
        end
        peri_req = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
